dmem_arbiter: RTL and testbench

Shares the single data-memory port between the pipeline's load/store stage (core) and a DMA/loader requester. Arbitration runs every cycle: the core has priority, a DMA starvation guard bounds DMA waiting, and an optional DMA lock gives bounded burst ownership. It drives the data memory's enable, write, address and write-data inputs, routes read data back with a one-cycle tag, and produces the core stall used to freeze the pipeline.

---
 rtl/dmem_arbiter_if.sv | 42 ++++
 rtl/dmem_arbiter.sv | 91 +++++++++
 tb/tb_dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core/DMA/memory signal bundle for the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              d_req;
  logic              d_we;
  logic              d_lock;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  logic              core_stall;

  modport master (
    output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_lock, d_addr, d_wdata, m_rdata,
    input  c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata, core_stall
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, d_req, d_we, d_lock, d_addr, d_wdata, m_rdata,
    output c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata, core_stall
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core-priority data-memory arbiter with DMA starvation guard and locked bursts
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 16
) (
  input logic          clk,
  input logic          reset_n,
  dmem_arbiter_if.slave bus
);
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [WW-1:0] WAIT_TOP = WW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LOCK_TOP = LW'(LOCK_MAX);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [LW-1:0] lock_cnt;
  logic          rd_pend;
  logic          rd_owner;
  logic          c_gnt;
  logic          d_gnt;

  // Grants are combinational so a requester sees gnt in the cycle it asks.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset_n) begin
      if (state == LOCKED)
        d_gnt = bus.d_req;
      else if (bus.c_req && !(bus.d_req && wait_cnt == WAIT_TOP))
        c_gnt = 1'b1;
      else
        d_gnt = bus.d_req;
    end
  end

  assign bus.c_gnt      = c_gnt;
  assign bus.d_gnt      = d_gnt;
  assign bus.core_stall = reset_n & bus.c_req & ~c_gnt;

  assign bus.m_en    = c_gnt | d_gnt;
  assign bus.m_we    = c_gnt ? bus.c_we    : (d_gnt & bus.d_we);
  assign bus.m_addr  = c_gnt ? bus.c_addr  : (d_gnt ? bus.d_addr  : {ADDR_W{1'b0}});
  assign bus.m_wdata = c_gnt ? bus.c_wdata : (d_gnt ? bus.d_wdata : {DATA_W{1'b0}});

  assign bus.c_rvalid = rd_pend & ~rd_owner;
  assign bus.d_rvalid = rd_pend & rd_owner;
  assign bus.c_rdata  = bus.c_rvalid ? bus.m_rdata : {DATA_W{1'b0}};
  assign bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : {DATA_W{1'b0}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB;
      wait_cnt <= '0;
      lock_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend  <= (c_gnt & ~bus.c_we) | (d_gnt & ~bus.d_we);
      rd_owner <= d_gnt;

      if (d_gnt || !bus.d_req)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_TOP)
        wait_cnt <= wait_cnt + 1'b1;

      case (state)
        ARB: begin
          if (d_gnt && bus.d_lock) begin
            state    <= LOCKED;
            lock_cnt <= LW'(1);
          end
        end
        LOCKED: begin
          // Leaving after the grant that reaches LOCK_MAX caps a burst at LOCK_MAX accesses.
          if (!bus.d_req || !bus.d_lock || (lock_cnt + 1'b1) == LOCK_TOP) begin
            state    <= ARB;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  localparam int SL = 4;
  localparam int LM = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL), .LOCK_MAX(LM)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  function automatic logic [31:0] init_val(int i);
    return (i == 16) ? 32'hCAFEF00D : (32'h1000_0000 + i * 32'h0000_0111);
  endfunction

  // Memory behind the arbiter: read data appears the cycle after a read access.
  logic [31:0] mem [256];
  logic [31:0] rdq;
  assign bus.m_rdata = rdq;
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    end else begin
      if (bus.m_en && !bus.m_we) rdq <= mem[bus.m_addr[7:0]];
      if (bus.m_en && bus.m_we) mem[bus.m_addr[7:0]] = bus.m_wdata;
    end
  end

  int n_pass, n_total;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model state
  bit          r_locked;
  int          r_wait, r_burst;
  bit          r_pend, r_pend_d;
  logic [31:0] r_pend_data;
  logic [31:0] shadow [256];

  task automatic model_reset();
    r_locked = 0; r_wait = 0; r_burst = 0; r_pend = 0; r_pend_d = 0; r_pend_data = '0;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
  endtask

  logic obs_c, obs_d, obs_stall, obs_crv, obs_drv;
  logic [31:0] obs_crd, obs_drd;

  task automatic drive_idle();
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_lock = 0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  // One cycle: inputs are already driven; check at negedge, advance the model, move past posedge.
  task automatic step();
    bit ec, ed, we;
    logic [31:0] a, wd;
    @(negedge clk);
    ec = 0; ed = 0;
    if (r_locked) ed = bus.d_req;
    else if (bus.c_req && (!bus.d_req || r_wait < SL)) ec = 1;
    else ed = bus.d_req;
    a  = ec ? bus.c_addr  : (ed ? bus.d_addr  : 32'h0);
    wd = ec ? bus.c_wdata : (ed ? bus.d_wdata : 32'h0);
    we = ec ? bus.c_we    : (ed ? bus.d_we    : 1'b0);

    chk("c_gnt", bus.c_gnt, ec);
    chk("d_gnt", bus.d_gnt, ed);
    chk("one_grant", bus.c_gnt & bus.d_gnt, 0);
    chk("m_en", bus.m_en, ec | ed);
    chk("m_we", bus.m_we, we);
    chk("m_addr", bus.m_addr, a);
    chk("m_wdata", bus.m_wdata, wd);
    chk("core_stall", bus.core_stall, bus.c_req & ~ec);
    chk("c_rvalid", bus.c_rvalid, r_pend & ~r_pend_d);
    chk("d_rvalid", bus.d_rvalid, r_pend & r_pend_d);
    chk("c_rdata", bus.c_rdata, (r_pend && !r_pend_d) ? r_pend_data : 32'h0);
    chk("d_rdata", bus.d_rdata, (r_pend && r_pend_d) ? r_pend_data : 32'h0);

    obs_c = bus.c_gnt; obs_d = bus.d_gnt; obs_stall = bus.core_stall;
    obs_crv = bus.c_rvalid; obs_drv = bus.d_rvalid; obs_crd = bus.c_rdata; obs_drd = bus.d_rdata;

    r_pend      = (ec || ed) && !we;
    r_pend_d    = ed;
    r_pend_data = shadow[a[7:0]];
    if ((ec || ed) && we) shadow[a[7:0]] = wd;

    if (bus.d_req && !ed) r_wait = (r_wait < SL) ? r_wait + 1 : SL;
    else r_wait = 0;

    if (!r_locked) begin
      if (ed && bus.d_lock) begin r_locked = 1; r_burst = 1; end
    end else if (!bus.d_req) begin
      r_locked = 0;
    end else begin
      r_burst++;
      if (!bus.d_lock || r_burst >= LM) r_locked = 0;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit       cr, cw;
    bit [7:0] ca;
    bit       dr, dw, dl;
    bit [7:0] da;
    bit       ecg, edg;
  } vec_t;
  vec_t tv [14];

  bit cseq [20];
  bit dseq [20];

  initial begin
    int  run;
    bit  core_done, cpend, dpend;
    n_pass = 0; n_total = 0;

    for (int i = 0; i < 10; i++)
      tv[i] = '{1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 8'h18, (i != 4 && i != 9), (i == 4 || i == 9)};
    tv[10] = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h30, 1'b0, 1'b1};
    tv[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[13] = '{1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 8'h13, 1'b1, 1'b0};

    // Reset state with both sides requesting
    drive_idle();
    bus.c_req = 1; bus.d_req = 1;
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_c_gnt", bus.c_gnt, 0);
    chk("rst_d_gnt", bus.d_gnt, 0);
    chk("rst_m_en", bus.m_en, 0);
    chk("rst_m_we", bus.m_we, 0);
    chk("rst_stall", bus.core_stall, 0);
    chk("rst_rvalid", {bus.c_rvalid, bus.d_rvalid}, 0);
    chk("rst_rdata", bus.c_rdata | bus.d_rdata, 0);
    @(negedge clk);
    drive_idle();
    reset_n = 1;
    @(posedge clk);
    #1;

    // Table vectors: starvation pattern and single-requester cases
    for (int i = 0; i < 14; i++) begin
      bus.c_req = tv[i].cr; bus.c_we = tv[i].cw; bus.c_addr = {24'h0, tv[i].ca}; bus.c_wdata = 32'h0;
      bus.d_req = tv[i].dr; bus.d_we = tv[i].dw; bus.d_lock = tv[i].dl;
      bus.d_addr = {24'h0, tv[i].da}; bus.d_wdata = 32'hDEAD0001;
      step();
      chk("tv_c_gnt", obs_c, tv[i].ecg);
      chk("tv_d_gnt", obs_d, tv[i].edg);
      chk("tv_stall", obs_stall, tv[i].cr & ~tv[i].ecg);
    end
    drive_idle();
    step();

    // Core-only read of a preloaded word
    bus.c_req = 1; bus.c_addr = 32'h10;
    step();
    chk("cafe_gnt", obs_c, 1);
    chk("cafe_stall", obs_stall, 0);
    drive_idle();
    step();
    chk("cafe_rvalid", obs_crv, 1);
    chk("cafe_rdata", obs_crd, 32'hCAFEF00D);

    // Locked DMA burst against a core with one pending read
    core_done = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus.d_req = 1; bus.d_lock = 1; bus.d_we = 0; bus.d_addr = 32'h8;
      bus.c_req = (cyc >= 1) && !core_done; bus.c_we = 0; bus.c_addr = 32'h4;
      step();
      if (obs_c) core_done = 1;
      cseq[cyc] = obs_c; dseq[cyc] = obs_d;
    end
    drive_idle();
    step();
    run = 0;
    for (int cyc = 0; cyc < 16; cyc++) run += int'(dseq[cyc]);
    chk("lock_run", run, 16);
    chk("lock_core_slot", {cseq[16], dseq[16]}, 2'b10);
    chk("lock_regain", {dseq[17], dseq[18], dseq[19]}, 3'b111);

    // Lock release after a 3-write burst; waiting core reads back the middle word
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive_idle();
      if (cyc < 3) begin
        bus.d_req = 1; bus.d_we = 1; bus.d_lock = (cyc != 2);
        bus.d_addr = 32'h20 + cyc; bus.d_wdata = cyc + 1;
      end
      if (cyc >= 1 && cyc <= 3) begin bus.c_req = 1; bus.c_addr = 32'h21; end
      step();
      if (cyc == 1 || cyc == 2) chk("rel_core_held", obs_c, 0);
      if (cyc == 3) chk("rel_core_gnt", obs_c, 1);
      if (cyc == 4) begin
        chk("rel_rvalid", obs_crv, 1);
        chk("rel_rdata", obs_crd, 32'd2);
      end
    end

    // Interleaved core/DMA reads
    for (int i = 0; i < 7; i++) begin
      drive_idle();
      if (i < 6) begin
        if (i % 2 == 0) begin bus.c_req = 1; bus.c_addr = 32'h4; end
        else begin bus.d_req = 1; bus.d_addr = 32'h8; end
      end
      step();
      if (i >= 1) begin
        chk("il_c_rvalid", obs_crv, ((i - 1) % 2) == 0);
        chk("il_d_rvalid", obs_drv, ((i - 1) % 2) == 1);
      end
    end

    // Reset while locked with a DMA read pending
    drive_idle();
    bus.d_req = 1; bus.d_lock = 1; bus.d_addr = 32'h8;
    step();
    step();
    bus.c_req = 1;
    reset_n = 0;
    #2;
    chk("mid_rst_d_rvalid", bus.d_rvalid, 0);
    chk("mid_rst_gnts", {bus.c_gnt, bus.d_gnt, bus.m_en}, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("mid_rst_hold_rvalid", {bus.c_rvalid, bus.d_rvalid}, 0);
    @(negedge clk);
    drive_idle();
    reset_n = 1;
    @(posedge clk);
    #1;
    bus.c_req = 1; bus.c_addr = 32'h10; bus.d_req = 1; bus.d_addr = 32'h8;
    step();
    chk("post_rst_core_gnt", obs_c, 1);

    // Randomized traffic with requesters holding until granted
    drive_idle();
    cpend = 0; dpend = 0;
    for (int n = 0; n < 800; n++) begin
      if (!cpend && $urandom_range(0, 2) != 0) begin
        cpend = 1; bus.c_we = $urandom_range(0, 1) == 1;
        bus.c_addr = 32'h40 + $urandom_range(0, 15); bus.c_wdata = $urandom;
      end
      if (!dpend && $urandom_range(0, 2) != 0) begin
        dpend = 1; bus.d_we = $urandom_range(0, 1) == 1;
        bus.d_lock = $urandom_range(0, 3) != 0;
        bus.d_addr = 32'h40 + $urandom_range(0, 15); bus.d_wdata = $urandom;
      end
      bus.c_req = cpend; bus.d_req = dpend;
      step();
      if (obs_c) cpend = 0;
      if (obs_d) dpend = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
